// File: rtl/mem_contention_pkg.sv
// Shared types and constants for the DRAM contention arbiter.
package mem_contention_pkg;

    localparam int unsigned NUM_TILES_DEF = 4;
    localparam int unsigned LEN_W_DEF     = 8;
    localparam int unsigned TOKEN_W_DEF   = 16;
    localparam int unsigned STALL_W_DEF   = 32;

    localparam logic [7:0] CSR_MEMC_CTRL   = 8'hD4;
    localparam logic [7:0] CSR_MEMC_TOKENS = 8'hD8;

    typedef enum logic [0:0] {
        IDLE,
        ISSUE
    } memc_state_t;

endpackage

// File: rtl/rr_token_picker.sv
// Combinational round-robin search: first valid tile at or above rr_ptr, wrapping.
module rr_token_picker #(
    parameter int unsigned NUM_TILES = 4,
    localparam int unsigned ID_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic [NUM_TILES-1:0] req_valid,
    input  logic [ID_W-1:0]      rr_ptr,
    output logic [ID_W-1:0]      cand,
    output logic                 found
);

    int unsigned idx;

    // Scan farthest offset first so the nearest valid tile is the last one written.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        idx   = 0;
        for (int k = NUM_TILES - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_TILES;
            if (req_valid[idx]) begin
                found = 1'b1;
                cand  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_contention_arbiter.sv
// Round-robin DRAM request arbiter gated by a shared token bucket with
// strict head-of-line blocking.
module mem_contention_arbiter
    import mem_contention_pkg::*;
#(
    parameter int unsigned NUM_TILES = NUM_TILES_DEF,
    parameter int unsigned LEN_W     = LEN_W_DEF,
    parameter int unsigned TOKEN_W   = TOKEN_W_DEF,
    parameter int unsigned STALL_W   = STALL_W_DEF,
    localparam int unsigned ID_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_enable,
    input  logic [7:0]                 cfg_refill,
    input  logic [TOKEN_W-1:0]         cfg_bucket_max,
    input  logic [NUM_TILES-1:0]       req_valid,
    input  logic [NUM_TILES*LEN_W-1:0] req_len,
    output logic [NUM_TILES-1:0]       req_ready,
    output logic                       mem_valid,
    output logic [ID_W-1:0]            mem_tile_id,
    output logic [LEN_W-1:0]           mem_len,
    input  logic                       mem_ready,
    output logic [TOKEN_W-1:0]         token_level,
    output logic [STALL_W-1:0]         stall_cycles
);

    localparam int unsigned SUM_W = TOKEN_W + 2;

    memc_state_t      state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  cand;
    logic             found;
    logic [LEN_W-1:0] cand_len;
    logic [LEN_W-1:0] eff_len;
    logic             tokens_ok;
    logic             grant;
    logic             blocked;
    logic [SUM_W-1:0] tok_ext;
    logic [SUM_W-1:0] eff_ext;
    logic [SUM_W-1:0] max_ext;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] consumed;
    logic [SUM_W-1:0] diff;
    logic [TOKEN_W-1:0] token_next;

    rr_token_picker #(
        .NUM_TILES(NUM_TILES)
    ) u_picker (
        .req_valid(req_valid),
        .rr_ptr   (rr_ptr),
        .cand     (cand),
        .found    (found)
    );

    always_comb begin
        cand_len  = req_len[32'(cand) * LEN_W +: LEN_W];
        eff_len   = (cand_len == '0) ? LEN_W'(1) : cand_len;
        tok_ext   = SUM_W'(token_level);
        eff_ext   = SUM_W'(eff_len);
        max_ext   = SUM_W'(cfg_bucket_max);
        tokens_ok = (tok_ext >= eff_ext);
        grant     = (state == IDLE) && found && (!cfg_enable || tokens_ok);
        blocked   = (state == IDLE) && found && cfg_enable && !tokens_ok;
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[cand] = 1'b1;
        end
    end

    // Refill and consumption are applied together, then clamped to [0, max].
    always_comb begin
        sum        = tok_ext + SUM_W'(cfg_refill);
        consumed   = (grant && cfg_enable) ? eff_ext : '0;
        diff       = '0;
        token_next = '0;
        if (!cfg_enable) begin
            token_next = cfg_bucket_max;
        end else if (sum < consumed) begin
            token_next = '0;
        end else begin
            diff = sum - consumed;
            if (diff > max_ext) begin
                token_next = cfg_bucket_max;
            end else begin
                token_next = diff[TOKEN_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            mem_valid    <= 1'b0;
            mem_tile_id  <= '0;
            mem_len      <= '0;
            token_level  <= cfg_bucket_max;
            stall_cycles <= '0;
        end else begin
            token_level <= token_next;
            case (state)
                IDLE: begin
                    if (grant) begin
                        mem_valid   <= 1'b1;
                        mem_tile_id <= cand;
                        mem_len     <= eff_len;
                        rr_ptr      <= (cand == ID_W'(NUM_TILES - 1)) ? '0 : cand + ID_W'(1);
                        state       <= ISSUE;
                    end else if (blocked && (stall_cycles != '1)) begin
                        stall_cycles <= stall_cycles + STALL_W'(1);
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    mem_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_contention_arbiter.sv
// Self-checking bench for mem_contention_arbiter against a behavioural model.
module tb_mem_contention_arbiter;

    localparam int N  = 4;
    localparam int LW = 8;
    localparam int TW = 16;
    localparam int SW = 32;
    localparam int IW = 2;
    localparam int VW = N + 1 + IW + LW + TW + SW;

    logic            clk = 1'b0;
    logic            reset;
    logic            cfg_enable;
    logic [7:0]      cfg_refill;
    logic [TW-1:0]   cfg_bucket_max;
    logic [N-1:0]    req_valid;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    req_ready;
    logic            mem_valid;
    logic [IW-1:0]   mem_tile_id;
    logic [LW-1:0]   mem_len;
    logic            mem_ready;
    logic [TW-1:0]   token_level;
    logic [SW-1:0]   stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit     m_busy;
    int     m_ptr;
    int     m_tok;
    int     m_tile;
    int     m_len;
    longint m_stall;

    mem_contention_arbiter #(
        .NUM_TILES(N),
        .LEN_W    (LW),
        .TOKEN_W  (TW),
        .STALL_W  (SW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_enable    (cfg_enable),
        .cfg_refill    (cfg_refill),
        .cfg_bucket_max(cfg_bucket_max),
        .req_valid     (req_valid),
        .req_len       (req_len),
        .req_ready     (req_ready),
        .mem_valid     (mem_valid),
        .mem_tile_id   (mem_tile_id),
        .mem_len       (mem_len),
        .mem_ready     (mem_ready),
        .token_level   (token_level),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic int eff(int i);
        int l;
        l = int'(req_len[i*LW +: LW]);
        return (l == 0) ? 1 : l;
    endfunction

    function automatic int m_cand();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit m_grant();
        int c;
        c = m_cand();
        if (m_busy || c < 0) return 1'b0;
        return !cfg_enable || (m_tok >= eff(c));
    endfunction

    function automatic logic [VW-1:0] m_vec();
        logic [N-1:0] rdy;
        logic [N-1:0] one;
        one = 1;
        rdy = m_grant() ? (one << m_cand()) : '0;
        return {rdy, m_busy, IW'(m_tile), LW'(m_len), TW'(m_tok), SW'(m_stall)};
    endfunction

    function automatic logic [VW-1:0] obs();
        return {req_ready, mem_valid, mem_tile_id, mem_len, token_level, stall_cycles};
    endfunction

    task automatic model_step();
        int c;
        int el;
        int t;
        bit g;
        c  = m_cand();
        el = (c >= 0) ? eff(c) : 0;
        g  = m_grant();
        if (reset) begin
            m_busy = 0; m_ptr = 0; m_tok = int'(cfg_bucket_max);
            m_stall = 0; m_tile = 0; m_len = 0;
            return;
        end
        if (!m_busy) begin
            if (g) begin
                m_busy = 1; m_tile = c; m_len = el; m_ptr = (c + 1) % N;
            end else if (c >= 0 && m_stall < 64'hFFFF_FFFF) begin
                m_stall++;
            end
        end else if (mem_ready) begin
            m_busy = 0;
        end
        if (!cfg_enable) begin
            m_tok = int'(cfg_bucket_max);
        end else begin
            t = m_tok + int'(cfg_refill) - (g ? el : 0);
            if (t < 0) t = 0;
            if (t > int'(cfg_bucket_max)) t = int'(cfg_bucket_max);
            m_tok = t;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_len(int i, int v);
        req_len[i*LW +: LW] = 8'(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cfg_enable = 1'b1; cfg_refill = 8'd0; cfg_bucket_max = 16'd100;
        req_valid = '0; req_len = '0; mem_ready = 1'b0;
        do_reset();
        #1;
        n_cmp++;
        if (obs() !== m_vec()) begin
            n_bad++; $display("FAIL reset_vec: got %h expected %h", obs(), m_vec());
        end
        n_cmp++;
        if ({mem_valid, mem_tile_id, mem_len, token_level, stall_cycles} !== {1'b0, 2'd0, 8'd0, 16'd100, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_vals: mv=%0b id=%0d len=%0d tok=%0d stall=%0d expected 0/0/0/100/0",
                     mem_valid, mem_tile_id, mem_len, token_level, stall_cycles);
        end
    endtask

    task automatic test_rr_no_tokens();
        int order[$];
        int want[5] = '{0, 1, 2, 3, 0};
        cfg_enable = 1'b0; cfg_bucket_max = 16'd100; cfg_refill = 8'd3;
        do_reset();
        req_valid = 4'hF; mem_ready = 1'b1;
        for (int i = 0; i < N; i++) set_len(i, 8);
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++;
            if (obs() !== m_vec()) begin
                n_bad++; $display("FAIL rr cyc%0d: got %h expected %h", i, obs(), m_vec());
            end
            for (int k = 0; k < N; k++) if (req_ready[k]) order.push_back(k);
            tick();
        end
        n_cmp++;
        if (order.size() != 5) begin
            n_bad++; $display("FAIL rr_count: got %0d grants expected 5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (order[k] != want[k]) begin
                    n_bad++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, order[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_token_exhaust();
        int grants;
        grants = 0;
        cfg_enable = 1'b1; cfg_bucket_max = 16'd64; cfg_refill = 8'd0;
        req_valid = '0;
        do_reset();
        req_valid = 4'b0001; set_len(0, 32); mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++;
            if (obs() !== m_vec()) begin
                n_bad++; $display("FAIL exhaust cyc%0d: got %h expected %h", i, obs(), m_vec());
            end
            if (req_ready[0]) grants++;
            tick();
        end
        n_cmp++;
        if (grants != 2 || token_level !== 16'd0 || stall_cycles !== 32'd4) begin
            n_bad++;
            $display("FAIL exhaust_end: grants=%0d tok=%0d stall=%0d expected 2/0/4",
                     grants, token_level, stall_cycles);
        end
        req_valid = '0;
    endtask

    task automatic test_refill_wait();
        cfg_enable = 1'b1; cfg_bucket_max = 16'd64; cfg_refill = 8'd0;
        req_valid = '0;
        do_reset();
        req_valid = 4'b0010; set_len(1, 64); mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                cfg_refill = 8'd4; set_len(1, 16);
            end
            #1;
            n_cmp++;
            if (obs() !== m_vec()) begin
                n_bad++; $display("FAIL refill cyc%0d: got %h expected %h", i, obs(), m_vec());
            end
            if (i >= 2 && i <= 4) begin
                n_cmp++;
                if (req_ready !== 4'b0000) begin
                    n_bad++; $display("FAIL refill_early cyc%0d: ready=%b expected 0000", i, req_ready);
                end
            end
            if (i == 5) begin
                n_cmp++;
                if (req_ready !== 4'b0010 || token_level !== 16'd16) begin
                    n_bad++;
                    $display("FAIL refill_grant: ready=%b tok=%0d expected 0010/16", req_ready, token_level);
                end
            end
            tick();
        end
        n_cmp++;
        if (token_level !== 16'd4) begin
            n_bad++; $display("FAIL refill_after: tok=%0d expected 4", token_level);
        end
        req_valid = '0;
    endtask

    task automatic test_hol_block();
        cfg_enable = 1'b1; cfg_bucket_max = 16'd100; cfg_refill = 8'd3;
        req_valid = '0;
        do_reset();
        req_valid = 4'b0101; set_len(0, 200); set_len(2, 1); mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++;
            if (obs() !== m_vec() || req_ready !== 4'b0000) begin
                n_bad++; $display("FAIL hol cyc%0d: got %h expected %h", i, obs(), m_vec());
            end
            tick();
        end
        n_cmp++;
        if (stall_cycles !== 32'd6 || mem_valid !== 1'b0) begin
            n_bad++; $display("FAIL hol_stall: stall=%0d mv=%0b expected 6/0", stall_cycles, mem_valid);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        cfg_enable = 1'b0; cfg_bucket_max = 16'd100; cfg_refill = 8'd0;
        req_valid = '0;
        do_reset();
        req_valid = 4'b1000; set_len(3, 5); mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== m_vec() || req_ready !== 4'b1000) begin
            n_bad++; $display("FAIL bp_grant: got %h expected %h", obs(), m_vec());
        end
        tick();
        req_valid = '0;
        for (int i = 0; i < N; i++) set_len(i, 7);
        cfg_enable = 1'b1; cfg_refill = 8'd9;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (obs() !== m_vec() || mem_valid !== 1'b1 || mem_tile_id !== 2'd3 ||
                mem_len !== 8'd5 || req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL bp_hold cyc%0d: mv=%0b id=%0d len=%0d rdy=%b expected 1/3/5/0000",
                         i, mem_valid, mem_tile_id, mem_len, req_ready);
            end
            tick();
        end
        mem_ready = 1'b1;
        tick();
        #1;
        n_cmp++;
        if (obs() !== m_vec() || mem_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_release: mv=%0b expected 0", mem_valid);
        end
    endtask

    task automatic test_reset_mid_issue();
        cfg_enable = 1'b1; cfg_bucket_max = 16'd100; cfg_refill = 8'd0;
        req_valid = '0;
        do_reset();
        req_valid = 4'b0100; set_len(2, 9); mem_ready = 1'b0;
        tick();
        req_valid = '0;
        #1;
        n_cmp++;
        if (mem_valid !== 1'b1 || token_level !== 16'd91) begin
            n_bad++; $display("FAIL rst_pre: mv=%0b tok=%0d expected 1/91", mem_valid, token_level);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== m_vec() || mem_valid !== 1'b0 || token_level !== 16'd100) begin
            n_bad++; $display("FAIL rst_mid: mv=%0b tok=%0d expected 0/100", mem_valid, token_level);
        end
        req_valid = 4'b1001; set_len(0, 0); set_len(3, 3);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL rst_ptr: ready=%b expected 0001", req_ready);
        end
        tick();
        #1;
        n_cmp++;
        if (obs() !== m_vec() || mem_len !== 8'd1 || mem_tile_id !== 2'd0) begin
            n_bad++; $display("FAIL rst_len0: len=%0d id=%0d expected 1/0", mem_len, mem_tile_id);
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        cfg_enable = 1'b1; cfg_bucket_max = 16'd80; cfg_refill = 8'd2;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 29) == 0) cfg_enable = ~cfg_enable;
            if ($urandom_range(0, 19) == 0) cfg_bucket_max = 16'($urandom_range(20, 200));
            if ($urandom_range(0, 9) == 0) cfg_refill = 8'($urandom_range(0, 7));
            req_valid = 4'($urandom_range(0, 15));
            for (int k = 0; k < N; k++) set_len(k, int'($urandom_range(0, 40)));
            mem_ready = ($urandom_range(0, 9) < 7);
            #1;
            n_cmp++;
            if (obs() !== m_vec()) begin
                n_bad++; $display("FAIL random cyc%0d: got %h expected %h", i, obs(), m_vec());
            end
            tick();
        end
        reset = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        reset = 1'b1; cfg_enable = 1'b0; cfg_refill = '0; cfg_bucket_max = 16'd100;
        req_valid = '0; req_len = '0; mem_ready = 1'b0;
        m_busy = 0; m_ptr = 0; m_tok = 0; m_tile = 0; m_len = 0; m_stall = 0;
        @(negedge clk);
        test_reset();
        test_rr_no_tokens();
        test_token_exhaust();
        test_refill_wait();
        test_hol_block();
        test_backpressure();
        test_reset_mid_issue();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
